alu_cmd_sequencer: RTL and testbench

//  Upstream command front-end for the iterative ALU. Buffers tagged ALU commands in a small FIFO
//  and issues them one at a time with the ALU's single-cycle valid pulse. Waits for the ALU's
//  one-cycle ready pulse, then presents the 64-bit result on a valid/ready response port.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_fifo.sv | 54 +++++
 rtl/alu_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: mode codes, FSM states and the buffered command.
package alu_seq_pkg;

  // Tag storage width inside the FIFO; the top-level TAG_W must not exceed it.
  localparam int TAG_MAX_W = 16;

  localparam logic [3:0] MODE_ADD       = 4'd0;
  localparam logic [3:0] MODE_SUB       = 4'd1;
  localparam logic [3:0] MODE_AND       = 4'd2;
  localparam logic [3:0] MODE_OR        = 4'd3;
  localparam logic [3:0] MODE_XOR       = 4'd4;
  localparam logic [3:0] MODE_NOR       = 4'd5;
  localparam logic [3:0] MODE_SLT       = 4'd6;
  localparam logic [3:0] MODE_SHR       = 4'd7;
  localparam logic [3:0] MODE_SHL       = 4'd8;
  localparam logic [3:0] MODE_MUL       = 4'd9;
  localparam logic [3:0] MODE_DIV       = 4'd10;
  localparam logic [3:0] MODE_MAX_LEGAL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } alu_seq_state_e;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [3:0]           mode;
    logic [TAG_MAX_W-1:0] tag;
  } alu_cmd_t;

  function automatic logic mode_is_legal(input logic [3:0] mode);
    return mode <= MODE_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO; full/empty come from registered pointers, so a pop never frees
// a slot for a push in the same cycle.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  alu_cmd_t push_data_i,
  input  logic     pop_i,
  output alu_cmd_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the iterative ALU: buffers tagged commands, issues one at a time and
// returns results on a valid/ready port. Optional WAIT watchdog under ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_valid,
  output logic [31:0]      alu_in_A,
  output logic [31:0]      alu_in_B,
  output logic [3:0]       alu_mode,
  input  logic             alu_ready,
  input  logic [63:0]      alu_out_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output alu_seq_state_e   dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits for ready, and the offered payload is held stable until it transfers.

  alu_seq_state_e   state_q;
  logic             alu_valid_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [3:0]       alu_mode_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic             rsp_valid_q;
  logic [63:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  alu_cmd_t cmd_in;
  alu_cmd_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     issue_go;
  logic     head_legal;
  logic     unused_tag_hi;

  assign cmd_in.a    = cmd_a;
  assign cmd_in.b    = cmd_b;
  assign cmd_in.mode = cmd_mode;
  assign cmd_in.tag  = TAG_MAX_W'(cmd_tag);

  alu_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_valid),
    .push_data_i (cmd_in),
    .pop_i       (issue_go),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_legal    = mode_is_legal(head.mode);
  assign unused_tag_hi = ^(head.tag >> TAG_W);
  // The head is popped on the edge that enters ISSUE, from IDLE or from an accepted RESP.
  assign issue_go      = !fifo_empty &&
                         ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  // Fires so that the error response appears TIMEOUT_CYCLES cycles after the alu_valid pulse.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  logic [TO_W-1:0] cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      alu_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: ;
        ST_ISSUE: begin
          if (illegal_q) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (alu_ready) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out_data;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b0;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Placed after the case so a new issue overrides the IDLE/RESP next-state above.
      if (issue_go) begin
        state_q     <= ST_ISSUE;
        tag_q       <= head.tag[TAG_W-1:0];
        illegal_q   <= !head_legal;
        alu_valid_q <= head_legal;
        if (head_legal) begin
          alu_a_q    <= head.a;
          alu_b_q    <= head.b;
          alu_mode_q <= head.mode;
        end
      end
    end
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign alu_valid   = alu_valid_q;
  assign alu_in_A    = alu_a_q;
  assign alu_in_B    = alu_b_q;
  assign alu_mode    = alu_mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an ALU stub (1-cycle ops, 34-cycle MUL/DIV).
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int CW = 80;
  localparam int RW = 69;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cmd_valid, cmd_ready;
  logic [31:0]    cmd_a, cmd_b;
  logic [3:0]     cmd_mode, cmd_tag;
  logic           alu_valid, alu_ready;
  logic [31:0]    alu_in_A, alu_in_B;
  logic [3:0]     alu_mode;
  logic [63:0]    alu_out_data;
  logic           rsp_valid, rsp_ready, rsp_err, busy;
  logic [63:0]    rsp_data;
  logic [3:0]     rsp_tag;
  alu_seq_state_e dbg_state;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .alu_valid(alu_valid), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B), .alu_mode(alu_mode),
    .alu_ready(alu_ready), .alu_out_data(alu_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rsp_word(input logic err, input logic [3:0] tag,
                                             input logic [63:0] data);
    return {err, tag, data};
  endfunction

  // ---------------- ALU stub ----------------
  logic stub_hang = 1'b0;
  logic stub_busy;
  int   stub_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ready    <= 1'b0;
      stub_busy    <= 1'b0;
      stub_left    <= 0;
      alu_out_data <= '0;
    end else begin
      alu_ready <= 1'b0;
      if (alu_valid && !stub_hang) begin
        if (alu_mode == 4'd9)       alu_out_data <= {32'h0, alu_in_A} * {32'h0, alu_in_B};
        else if (alu_mode == 4'd0)  alu_out_data <= {32'h0, alu_in_A + alu_in_B};
        else                        alu_out_data <= {32'h0, alu_in_A ^ alu_in_B};
        if (alu_mode >= 4'd9) begin
          stub_busy <= 1'b1;
          stub_left <= 33;
        end else begin
          alu_ready <= 1'b1;
        end
      end else if (stub_busy) begin
        if (stub_left == 1) begin
          alu_ready <= 1'b1;
          stub_busy <= 1'b0;
        end
        stub_left <= stub_left - 1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  logic          prev_valid = 1'b0;
  int            valid_cnt = 0;
  int            rsp_cnt = 0;
  int            exp_total = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_valid) begin
        check("alu_valid_gap", prev_valid, 1'b0);
        valid_cnt++;
      end
      prev_valid = alu_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp_err, rsp_tag, rsp_data}, '1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rsp", {rsp_err, rsp_tag, rsp_data}, mon_exp);
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_rsp(input logic err, input logic [3:0] tag, input logic [63:0] data);
    exp_q.push_back(rsp_word(err, tag, data));
    exp_total++;
  endtask

  // Called just after a rising edge; returns after the accepting edge (+1).
  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] mode,
                          input logic [3:0] tag, output int waited);
    cmd_a = a; cmd_b = b; cmd_mode = mode; cmd_tag = tag; cmd_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) check("push_timeout", 1'b0, 1'b1);
    else @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts falling edges until rsp_valid is seen (first falling edge counts as 1).
  task automatic wait_rsp(input int bound, output int k, output int busy_low);
    k = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      k++;
      if (!busy) busy_low++;
    end while (!rsp_valid && k < bound);
    if (!rsp_valid) check("rsp_wait_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed tests ----------------
  int w, w5, k, bl, n, v0, rsp_seen;

  initial begin
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alu", {alu_valid, alu_mode, alu_in_A, alu_in_B}, '0);
    check("rst_rsp", {rsp_valid, rsp_err, busy, rsp_tag, rsp_data}, '0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: ADD 5+7, tag 1; latency accept+1 / +2 / +3
    v0 = valid_cnt;
    expect_rsp(1'b0, 4'd1, 64'd12);
    push_cmd(32'd5, 32'd7, MODE_ADD, 4'd1, w);
    check("t1_accept_wait", w, 0);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_no_valid_yet", alu_valid, 1'b0);
    @(negedge clk);
    check("t1_alu_valid", alu_valid, 1'b1);
    check("t1_alu_in", {alu_mode, alu_in_A, alu_in_B}, {4'd0, 32'd5, 32'd7});
    @(negedge clk);
    check("t1_alu_ready", {alu_ready, alu_valid}, 2'b10);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_idle", busy, 1'b0);
    check("t1_pulses", valid_cnt - v0, 1);

    // 2: MUL 0x10000*0x10000 -> 0x1_0000_0000, 34-cycle stub
    @(posedge clk); #1;
    v0 = valid_cnt;
    expect_rsp(1'b0, 4'd2, 64'h1_0000_0000);
    push_cmd(32'h1_0000, 32'h1_0000, MODE_MUL, 4'd2, w);
    wait_rsp(100, k, bl);
    check("t2_latency", k, 37);
    check("t2_busy_low", bl, 0);
    @(posedge clk); #1;
    check("t2_pulses", valid_cnt - v0, 1);

    // 3: back-pressure, six ADDs, order preserved
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_rsp(1'b0, 4'(i), 64'(100 + i));
      push_cmd(32'(i), 32'd100, MODE_ADD, 4'(i), w);
      check("t3_accept_wait", w, 0);
    end
    @(negedge clk);
    check("t3_full", cmd_ready, 1'b0);
    expect_rsp(1'b0, 4'd5, 64'd105);
    @(posedge clk); #1;
    fork
      push_cmd(32'd5, 32'd100, MODE_ADD, 4'd5, w5);
      begin
        repeat (6) @(negedge clk);
        check("t3_still_full", cmd_ready, 1'b0);
        check("t3_held_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, 64'd100});
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    check("t3_tag5_blocked", (w5 > 5), 1'b1);
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t3_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // 4: illegal mode 12, tag 3
    v0 = valid_cnt;
    expect_rsp(1'b1, 4'd3, 64'd0);
    push_cmd(32'd1, 32'd2, 4'b1100, 4'd3, w);
    wait_rsp(20, k, bl);
    check("t4_latency", k, 3);
    @(posedge clk); #1;
    check("t4_no_valid", valid_cnt - v0, 0);

    // 5: ALU never answers
    stub_hang = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
    expect_rsp(1'b1, 4'd7, 64'd0);
    push_cmd(32'd3, 32'd4, MODE_ADD, 4'd7, w);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!alu_valid && k < 10);
    check("t5_valid_seen", alu_valid, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    check("t5_timeout_cycles", n, 64);
    @(posedge clk); #1;
`else
    push_cmd(32'd3, 32'd4, MODE_ADD, 4'd7, w);
    bl = 0;
    rsp_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) bl++;
      if (rsp_valid) rsp_seen++;
    end
    check("t5_busy_low", bl, 0);
    check("t5_no_rsp", rsp_seen, 0);
    check("t5_state", dbg_state, ST_WAIT);
    @(posedge clk); #1;
`endif
    stub_hang = 1'b0;
    do_reset(3);

    // 6: reset in the middle of a DIV
    push_cmd(32'd100, 32'd7, MODE_DIV, 4'd9, w);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_alu", {alu_valid, alu_mode, alu_in_A, alu_in_B}, '0);
    check("t6_rst_rsp", {rsp_valid, rsp_err, busy, rsp_tag, rsp_data}, '0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_ready", {cmd_ready, busy}, 2'b10);
    @(posedge clk); #1;
    expect_rsp(1'b0, 4'd2, 64'd42);
    push_cmd(32'd20, 32'd22, MODE_ADD, 4'd2, w);
    wait_rsp(20, k, bl);
    check("t6_latency", k, 4);
    @(posedge clk); #1;
    repeat (40) @(negedge clk);

    check("final_queue", exp_q.size(), 0);
    check("final_rsp_count", rsp_cnt, exp_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
